// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and widths for the program-counter fetch controller.
// Holds the state encoding, fault-cause codes and the PC/instruction widths.
package pc_fetch_ctrl_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_TIMEOUT  = 2'b10
  } fault_code_e;

  function automatic logic pc_aligned(input logic [PC_W-1:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between fetch control and memory.
interface pc_fetch_ctrl_if
  import pc_fetch_ctrl_pkg::*;
  ();

  logic               IMemReq;
  logic [PC_W-1:0]    IMemAddr;
  logic               IMemAck;
  logic [INSTR_W-1:0] IMemData;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemAck,
    input  IMemData
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemAck,
    output IMemData
  );

endinterface

// File: rtl/pc_fetch_ctrl_timeout_ctr.sv
// Clearable up-counter flagging the last permitted wait cycle of a fetch.
module fetch_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [15:0] TC_VAL = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Terminal count marks the TIMEOUT-th unacknowledged cycle, not the one after.
  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Architectural PC register and single-outstanding instruction fetch sequencer.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNTW     = 32
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [PC_W-1:0]       NextPC,
  input  logic                  NextPCValid,
  pc_fetch_ctrl_if.master       imem,
  output logic [INSTR_W-1:0]    Instruction,
  output logic                  InstrValid,
  output logic [PC_W-1:0]       CurrentPC,
  output logic [CNTW-1:0]       RetiredCount,
  output logic                  Fault,
  output logic [1:0]            FaultCode
);

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               req_q;
  logic [CNTW-1:0]    retired_q;
  logic               fault_q;
  fault_code_e        fc_q;

  logic tmo_tc;
  logic tmo_inc;
  logic tmo_clr;

  assign tmo_inc = (state_q == ST_FETCH) && req_q && !imem.IMemAck;
  assign tmo_clr = (state_q != ST_FETCH) || imem.IMemAck;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i (CLK),
    .rst_i (Reset),
    .clr_i (tmo_clr),
    .inc_i (tmo_inc),
    .tc_o  (tmo_tc)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      fc_q      <= FC_NONE;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          // req_q low only on the first cycle out of reset; no request is open yet.
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem.IMemAck) begin
            instr_q <= imem.IMemData;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= ST_HOLD;
          end else if (tmo_tc) begin
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            fc_q    <= FC_TIMEOUT;
            state_q <= ST_FAULT;
          end
        end
        ST_HOLD: begin
          if (NextPCValid) begin
            valid_q <= 1'b0;
            if (pc_aligned(NextPC)) begin
              pc_q      <= NextPC;
              retired_q <= retired_q + CNTW'(1);
              req_q     <= 1'b1;
              state_q   <= ST_FETCH;
            end else begin
              fault_q <= 1'b1;
              fc_q    <= FC_MISALIGN;
              state_q <= ST_FAULT;
            end
          end
        end
        ST_FAULT: begin
        end
        default: begin
          state_q <= ST_FAULT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.IMemReq  = req_q;
  assign imem.IMemAddr = pc_q;
  assign Instruction   = instr_q;
  assign InstrValid    = valid_q;
  assign CurrentPC     = pc_q;
  assign RetiredCount  = retired_q;
  assign Fault         = fault_q;
  assign FaultCode     = fc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and randomized checks of pc_fetch_ctrl against a behavioural model.
module tb_pc_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          TIMEOUT  = 16;
  localparam int          CNTW     = 32;

  localparam int M_START = 0;
  localparam int M_FETCH = 1;
  localparam int M_HOLD  = 2;
  localparam int M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] npc;
  logic        npv;
  logic [31:0] instr;
  logic        ivalid;
  logic [63:0] cur_pc;
  logic [CNTW-1:0] retired;
  logic        fault;
  logic [1:0]  fcode;

  pc_fetch_ctrl_if imem ();

  pc_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT),
    .CNTW     (CNTW)
  ) dut (
    .CLK          (clk),
    .Reset        (rst),
    .NextPC       (npc),
    .NextPCValid  (npv),
    .imem         (imem),
    .Instruction  (instr),
    .InstrValid   (ivalid),
    .CurrentPC    (cur_pc),
    .RetiredCount (retired),
    .Fault        (fault),
    .FaultCode    (fcode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the architecturally visible state.
  int              m_mode = M_START;
  int              m_wait = 0;
  logic [63:0]     m_pc   = RESET_PC;
  logic [31:0]     m_instr = '0;
  logic            m_iv   = 1'b0;
  logic [CNTW-1:0] m_ret  = '0;
  logic            m_fault = 1'b0;
  logic [1:0]      m_code = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_mode = M_START; m_wait = 0; m_pc = RESET_PC; m_instr = '0;
      m_iv = 1'b0; m_ret = '0; m_fault = 1'b0; m_code = 2'b00;
    end else begin
      case (m_mode)
        M_START: begin
          m_mode = M_FETCH;
          m_wait = 0;
        end
        M_FETCH: begin
          if (imem.IMemAck) begin
            m_instr = imem.IMemData;
            m_iv    = 1'b1;
            m_mode  = M_HOLD;
            m_wait  = 0;
          end else begin
            m_wait = m_wait + 1;
            if (m_wait >= TIMEOUT) begin
              m_mode = M_FAULT; m_fault = 1'b1; m_code = 2'b10;
            end
          end
        end
        M_HOLD: begin
          if (npv) begin
            m_iv = 1'b0;
            if (npc % 4 == 0) begin
              m_pc   = npc;
              m_ret  = m_ret + 1;
              m_mode = M_FETCH;
              m_wait = 0;
            end else begin
              m_mode = M_FAULT; m_fault = 1'b1; m_code = 2'b01;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("IMemReq",      64'(imem.IMemReq), 64'(m_mode == M_FETCH));
    chk("IMemAddr",     imem.IMemAddr,     m_pc);
    chk("Instruction",  64'(instr),        64'(m_instr));
    chk("InstrValid",   64'(ivalid),       64'(m_iv));
    chk("CurrentPC",    cur_pc,            m_pc);
    chk("RetiredCount", 64'(retired),      64'(m_ret));
    chk("Fault",        64'(fault),        64'(m_fault));
    chk("FaultCode",    64'(fcode),        64'(m_code));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; npv = 1'b0; npc = '0;
    imem.IMemAck = 1'b0; imem.IMemData = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  int ack_pct;

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("lit_reset_req", 64'(imem.IMemReq), 64'd0);
    chk("lit_reset_pc",  cur_pc, 64'd0);
    chk("lit_reset_iv",  64'(ivalid), 64'd0);
    rst = 1'b0;
    step();
    chk("lit_first_req",  64'(imem.IMemReq), 64'd1);
    chk("lit_first_addr", imem.IMemAddr, 64'd0);

    imem.IMemAck = 1'b1; imem.IMemData = 32'h8B020020;
    step();
    imem.IMemAck = 1'b0;
    chk("lit_fetch_instr", 64'(instr), 64'h8B020020);
    chk("lit_fetch_iv",    64'(ivalid), 64'd1);
    chk("lit_fetch_req",   64'(imem.IMemReq), 64'd0);

    npv = 1'b1; npc = 64'd4;
    step();
    npv = 1'b0;
    chk("lit_pc4",      cur_pc, 64'd4);
    chk("lit_ret1",     64'(retired), 64'd1);
    chk("lit_req_at4",  64'(imem.IMemReq), 64'd1);
    chk("lit_addr4",    imem.IMemAddr, 64'd4);

    imem.IMemAck = 1'b1; imem.IMemData = 32'h1234_5678;
    step();
    imem.IMemAck = 1'b0;
    npv = 1'b1; npc = 64'd20;
    step();
    npv = 1'b0;
    chk("lit_pc20", cur_pc, 64'd20);
    chk("lit_ret2", 64'(retired), 64'd2);

    imem.IMemAck = 1'b1;
    step();
    imem.IMemAck = 1'b0;
    npv = 1'b1; npc = 64'd14;
    step();
    chk("lit_mis_fault", 64'(fault), 64'd1);
    chk("lit_mis_code",  64'(fcode), 64'd1);
    chk("lit_mis_pc",    cur_pc, 64'd20);
    npc = 64'd8; imem.IMemAck = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("lit_fault_req", 64'(imem.IMemReq), 64'd0);
    chk("lit_fault_ret", 64'(retired), 64'd2);

    // Ack withheld for the full budget.
    do_reset();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("lit_tmo_not_yet", 64'(fault), 64'd0);
    step();
    chk("lit_tmo_fault", 64'(fault), 64'd1);
    chk("lit_tmo_code",  64'(fcode), 64'd2);

    // Ack on the last permitted cycle wins.
    do_reset();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    imem.IMemAck = 1'b1; imem.IMemData = 32'hCAFE_0001;
    step();
    imem.IMemAck = 1'b0;
    chk("lit_late_ack_fault", 64'(fault), 64'd0);
    chk("lit_late_ack_iv",    64'(ivalid), 64'd1);

    // 64-bit wrap of the PC.
    npv = 1'b1; npc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    npv = 1'b0; imem.IMemAck = 1'b1;
    step();
    imem.IMemAck = 1'b0; npv = 1'b1; npc = 64'd0;
    step();
    npv = 1'b0;
    chk("lit_wrap_pc", cur_pc, 64'd0);

    // Reset mid-fetch at PC 20 with a simultaneous ack.
    imem.IMemAck = 1'b1;
    step();
    imem.IMemAck = 1'b0; npv = 1'b1; npc = 64'd20;
    step();
    npv = 1'b0;
    rst = 1'b1; imem.IMemAck = 1'b1; imem.IMemData = 32'hDEAD_BEEF;
    step();
    chk("lit_rst_instr", 64'(instr), 64'd0);
    chk("lit_rst_iv",    64'(ivalid), 64'd0);
    chk("lit_rst_pc",    cur_pc, 64'd0);
    rst = 1'b0; imem.IMemAck = 1'b0;
    step();
    npv = 1'b1; npc = 64'd40;
    step();
    npv = 1'b0;
    chk("lit_npv_in_fetch", cur_pc, 64'd0);

    // Randomized traffic.
    ack_pct = 30;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 50 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 2;
          1: ack_pct = 25;
          default: ack_pct = 80;
        endcase
      end
      rst = ($urandom_range(0, 99) == 0);
      if (m_mode == M_FETCH)
        imem.IMemAck = ($urandom_range(0, 99) < ack_pct);
      else
        imem.IMemAck = ($urandom_range(0, 9) == 0);
      imem.IMemData = $urandom;
      npv = ($urandom_range(0, 3) == 0);
      npc = {$urandom, $urandom};
      if ($urandom_range(0, 14) != 0) npc[1:0] = 2'b00;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
